aud_dsp_player: RTL and testbench

Parametrised playback engine between the SRAM recorder buffer and the DAC serialiser. Plays samples from address 0 up to a stop address, advancing once per DAC frame on the falling edge of i_daclrck. Supports integer-factor speed-up (sample skip) and integer-factor slow-down. Slow-down uses either zero-order hold or linear interpolation. Provides play, pause/resume and stop control.

---
 rtl/aud_pkg.sv | 21 ++
 rtl/aud_interp_div.sv | 74 +++++++
 rtl/aud_dsp_player.sv | 179 +++++++++++++++++
 tb/tb_aud_dsp_player.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared types and default sizes for the audio playback engine.
package aud_pkg;

    localparam int AUD_DATA_W  = 16;
    localparam int AUD_ADDR_W  = 20;
    localparam int AUD_SPEED_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_NORMAL = 2'd0,
        M_FAST   = 2'd1,
        M_SLOW0  = 2'd2,
        M_SLOW1  = 2'd3
    } mode_t;

endpackage

// File: rtl/aud_interp_div.sv
// Sequential signed restoring divider (quotient truncated toward zero) with
// start/done handshake and abort.
module aud_interp_div #(
    parameter int NUM_W = 20,
    parameter int DEN_W = 5,
    parameter int OUT_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic signed [NUM_W-1:0] i_num,
    input  logic signed [DEN_W-1:0] i_den,
    output logic signed [OUT_W-1:0] o_quo,
    output logic                    o_done,
    output logic                    o_busy
);

    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam int REM_W = DEN_W + 1;

    logic [NUM_W-1:0] quo;
    logic [REM_W-1:0] rem;
    logic [DEN_W-1:0] den_mag;
    logic [CNT_W-1:0] cnt;
    logic             neg;

    logic [REM_W-1:0] trial;
    logic             fits;
    logic [NUM_W-1:0] quo_nxt;

    // Division runs on magnitudes; the sign is restored on the final quotient.
    always_comb begin
        trial   = {rem[REM_W-2:0], quo[NUM_W-1]};
        fits    = (trial >= {1'b0, den_mag});
        quo_nxt = {quo[NUM_W-2:0], fits};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            quo     <= '0;
            rem     <= '0;
            den_mag <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            o_quo   <= '0;
            o_done  <= 1'b0;
            o_busy  <= 1'b0;
        end else if (i_abort) begin
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else if (i_start) begin
            quo     <= i_num[NUM_W-1] ? NUM_W'(-i_num) : NUM_W'(i_num);
            den_mag <= i_den[DEN_W-1] ? DEN_W'(-i_den) : DEN_W'(i_den);
            neg     <= i_num[NUM_W-1] ^ i_den[DEN_W-1];
            rem     <= '0;
            cnt     <= CNT_W'(NUM_W);
            o_busy  <= 1'b1;
            o_done  <= 1'b0;
        end else if (o_busy) begin
            quo <= quo_nxt;
            rem <= fits ? (trial - {1'b0, den_mag}) : trial;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                o_busy <= 1'b0;
                o_done <= 1'b1;
                o_quo  <= OUT_W'(neg ? -quo_nxt : quo_nxt);
            end
        end else begin
            o_done <= 1'b0;
        end
    end

endmodule

// File: rtl/aud_dsp_player.sv
// SRAM-to-DAC playback engine: one sample step per DAC frame, with sample-skip
// speed-up and hold or linearly interpolated slow-down.
module aud_dsp_player
    import aud_pkg::*;
#(
    parameter int DATA_W  = AUD_DATA_W,
    parameter int ADDR_W  = AUD_ADDR_W,
    parameter int SPEED_W = AUD_SPEED_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_pause,
    input  logic                      i_stop,
    input  logic [SPEED_W-1:0]        i_speed,
    input  logic                      i_fast,
    input  logic                      i_slow_0,
    input  logic                      i_slow_1,
    input  logic                      i_daclrck,
    input  logic signed [DATA_W-1:0]  i_sram_data,
    input  logic [ADDR_W-1:0]         i_stop_addr,
    output logic signed [DATA_W-1:0]  o_dac_data,
    output logic [ADDR_W-1:0]         o_sram_addr,
    output logic [1:0]                o_state
);

    localparam int NUM_W = DATA_W + SPEED_W + 1;
    localparam int DEN_W = SPEED_W + 2;

    state_t                    state;
    mode_t                     mode;
    mode_t                     mode_in;
    logic [SPEED_W:0]          f;
    logic [SPEED_W:0]          f_in;
    logic [SPEED_W-1:0]        k;
    logic [SPEED_W-1:0]        k_nxt;
    logic signed [DATA_W-1:0]  prev;
    logic                      dac_q;

    logic                      tick;
    logic                      k_last;
    logic [SPEED_W:0]          step;
    logic [ADDR_W:0]           next_addr;
    logic [ADDR_W-1:0]         addr_adv;
    logic                      at_end;
    logic                      leave_play;

    logic signed [NUM_W-1:0]   prev_x;
    logic signed [NUM_W-1:0]   cur_x;
    logic signed [NUM_W-1:0]   w_prev;
    logic signed [NUM_W-1:0]   w_cur;
    logic signed [NUM_W-1:0]   div_num;
    logic signed [DEN_W-1:0]   div_den;
    logic                      div_start;
    logic                      div_abort;
    logic                      div_done;
    logic                      div_busy;
    logic signed [DATA_W-1:0]  div_quo;

    assign tick    = dac_q & ~i_daclrck;
    assign o_state = state;

    always_comb begin
        if (i_fast)        mode_in = M_FAST;
        else if (i_slow_1) mode_in = M_SLOW1;
        else if (i_slow_0) mode_in = M_SLOW0;
        else               mode_in = M_NORMAL;
        f_in = {1'b0, i_speed} + (SPEED_W+1)'(1);
    end

    always_comb begin
        k_last = (({1'b0, k} + (SPEED_W+1)'(1)) >= f);
        k_nxt  = k_last ? '0 : (k + SPEED_W'(1));
        case (mode)
            M_FAST:           step = f;
            M_SLOW0, M_SLOW1: step = k_last ? (SPEED_W+1)'(1) : '0;
            default:          step = (SPEED_W+1)'(1);
        endcase
        // Addresses are clamped at the stop address so they never overshoot it.
        next_addr = {1'b0, o_sram_addr} + (ADDR_W+1)'(step);
        addr_adv  = (next_addr >= {1'b0, i_stop_addr}) ? i_stop_addr : next_addr[ADDR_W-1:0];
        // End detection waits for an in-flight interpolation so the last value is shown.
        at_end     = (state == S_PLAY) && (o_sram_addr >= i_stop_addr) && !div_busy && !div_done;
        leave_play = (state == S_PLAY) && (i_stop || at_end || i_pause);
        div_start  = (state == S_PLAY) && !leave_play && tick && (mode == M_SLOW1);
        div_abort  = (state != S_PLAY) || leave_play;
    end

    always_comb begin
        prev_x  = {{(NUM_W-DATA_W){prev[DATA_W-1]}}, prev};
        cur_x   = {{(NUM_W-DATA_W){i_sram_data[DATA_W-1]}}, i_sram_data};
        w_prev  = NUM_W'(f) - NUM_W'(k);
        w_cur   = NUM_W'(k);
        // With F=1 the weighted form would lag by one sample; pass the current one.
        div_num = (f == (SPEED_W+1)'(1)) ? cur_x : (prev_x * w_prev + cur_x * w_cur);
        div_den = DEN_W'(f);
    end

    aud_interp_div #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W),
        .OUT_W (DATA_W)
    ) u_div (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (div_start),
        .i_abort (div_abort),
        .i_num   (div_num),
        .i_den   (div_den),
        .o_quo   (div_quo),
        .o_done  (div_done),
        .o_busy  (div_busy)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            mode        <= M_NORMAL;
            f           <= '0;
            k           <= '0;
            prev        <= '0;
            dac_q       <= 1'b0;
            o_sram_addr <= '0;
            o_dac_data  <= '0;
        end else begin
            dac_q <= i_daclrck;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state       <= S_PLAY;
                        mode        <= mode_in;
                        f           <= f_in;
                        k           <= '0;
                        prev        <= '0;
                        o_sram_addr <= '0;
                        o_dac_data  <= '0;
                    end
                end
                S_PLAY: begin
                    if (i_stop || at_end) begin
                        state       <= S_IDLE;
                        k           <= '0;
                        prev        <= '0;
                        o_sram_addr <= '0;
                        o_dac_data  <= '0;
                    end else if (i_pause) begin
                        state      <= S_PAUSE;
                        o_dac_data <= '0;
                    end else begin
                        if (tick) begin
                            o_sram_addr <= addr_adv;
                            if (mode != M_SLOW1) o_dac_data <= i_sram_data;
                            if (mode == M_SLOW0 || mode == M_SLOW1) k <= k_nxt;
                            if (mode == M_SLOW1 && k_last) prev <= i_sram_data;
                        end
                        if (div_done) o_dac_data <= div_quo;
                    end
                end
                S_PAUSE: begin
                    if (i_stop) begin
                        state       <= S_IDLE;
                        k           <= '0;
                        prev        <= '0;
                        o_sram_addr <= '0;
                        o_dac_data  <= '0;
                    end else if (i_start) begin
                        state <= S_PLAY;
                        mode  <= mode_in;
                        f     <= f_in;
                        // A smaller new factor must not leave the hold counter out of range.
                        if ({1'b0, k} >= f_in) k <= SPEED_W'(f_in - (SPEED_W+1)'(1));
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aud_dsp_player.sv
// Self-checking bench for aud_dsp_player against a sample-sequence reference model.
module tb_aud_dsp_player;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 20;
    localparam int SPEED_W = 3;
    localparam int HI_CYC  = 12;
    localparam int LO_CYC  = 24;
    localparam int LAT_INT = 22;

    logic                     i_clk;
    logic                     i_rst;
    logic                     i_start;
    logic                     i_pause;
    logic                     i_stop;
    logic [SPEED_W-1:0]       i_speed;
    logic                     i_fast;
    logic                     i_slow_0;
    logic                     i_slow_1;
    logic                     i_daclrck;
    logic signed [DATA_W-1:0] i_sram_data;
    logic [ADDR_W-1:0]        i_stop_addr;
    logic signed [DATA_W-1:0] o_dac_data;
    logic [ADDR_W-1:0]        o_sram_addr;
    logic [1:0]               o_state;

    logic signed [DATA_W-1:0] mem [64];
    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    aud_dsp_player #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SPEED_W (SPEED_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_pause     (i_pause),
        .i_stop      (i_stop),
        .i_speed     (i_speed),
        .i_fast      (i_fast),
        .i_slow_0    (i_slow_0),
        .i_slow_1    (i_slow_1),
        .i_daclrck   (i_daclrck),
        .i_sram_data (i_sram_data),
        .i_stop_addr (i_stop_addr),
        .o_dac_data  (o_dac_data),
        .o_sram_addr (o_sram_addr),
        .o_state     (o_state)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    assign i_sram_data = mem[o_sram_addr[5:0]];

    // Expected sample stream of a full play-through, straight from the playback rules.
    task automatic model_fill(input int mode, input int f, input int stop);
        int prv;
        exp_q.delete();
        prv = 0;
        case (mode)
            0, 1: begin
                for (int p = 0; p < stop; p += ((mode == 1) ? f : 1)) exp_q.push_back(int'(mem[p]));
            end
            2: begin
                for (int p = 0; p < stop; p++)
                    for (int j = 0; j < f; j++) exp_q.push_back(int'(mem[p]));
            end
            default: begin
                for (int p = 0; p < stop; p++) begin
                    for (int j = 0; j < f; j++) begin
                        if (f == 1) exp_q.push_back(int'(mem[p]));
                        else exp_q.push_back(((f - j) * prv + j * int'(mem[p])) / f);
                    end
                    prv = int'(mem[p]);
                end
            end
        endcase
    endtask

    task automatic set_mode(input int mode, input int spd);
        i_fast   = (mode == 1);
        i_slow_0 = (mode == 2);
        i_slow_1 = (mode == 3);
        i_speed  = SPEED_W'(spd);
    endtask

    task automatic tick(input int lat);
        i_daclrck = 1'b1;
        repeat (HI_CYC) @(negedge i_clk);
        i_daclrck = 1'b0;
        repeat (lat) @(negedge i_clk);
    endtask

    task automatic tail(input int lat);
        repeat (LO_CYC - lat) @(negedge i_clk);
    endtask

    task automatic start_play();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic run_playback(input string name, input int mode, input int spd, input int stop);
        int lat;
        set_mode(mode, spd);
        i_stop_addr = ADDR_W'(stop);
        model_fill(mode, spd + 1, stop);
        lat = (mode == 3) ? LAT_INT : 1;
        start_play();
        i_speed  = SPEED_W'($urandom);
        i_fast   = 1'($urandom);
        i_slow_0 = 1'($urandom);
        i_slow_1 = 1'($urandom);
        n_cmp++;
        if (o_state !== 2'd1) begin
            n_bad++;
            $display("FAIL %s start_state got %0d want 1", name, o_state);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tick(lat);
            n_cmp++;
            if (o_dac_data !== DATA_W'(exp_q[i])) begin
                n_bad++;
                $display("FAIL %s sample[%0d] got %0d want %0d", name, i, o_dac_data, exp_q[i]);
            end
            n_cmp++;
            if (o_sram_addr > i_stop_addr) begin
                n_bad++;
                $display("FAIL %s overshoot[%0d] addr got %0d want <= %0d", name, i, o_sram_addr, stop);
            end
            tail(lat);
        end
        tick(lat);
        tail(lat);
        n_cmp++;
        if (o_state !== 2'd0 || o_sram_addr !== '0 || o_dac_data !== '0) begin
            n_bad++;
            $display("FAIL %s end state/addr/data got %0d/%0d/%0d want 0/0/0",
                     name, o_state, o_sram_addr, o_dac_data);
        end
        set_mode(0, 0);
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        i_daclrck = 1'b0; i_stop_addr = '0;
        set_mode(0, 0);
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (3) @(negedge i_clk);
        n_cmp++;
        if (o_state !== 2'd0 || o_sram_addr !== '0 || o_dac_data !== '0) begin
            n_bad++;
            $display("FAIL reset state/addr/data got %0d/%0d/%0d want 0/0/0", o_state, o_sram_addr, o_dac_data);
        end
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        n_cmp++;
        if (o_state !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_release state got %0d want 0", o_state);
        end
    endtask

    task automatic test_normal();
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'(100 * (i + 1));
        run_playback("normal", 0, 0, 4);
    endtask

    task automatic test_fast();
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'(7 * i + 1);
        run_playback("fast", 1, 2, 10);
    endtask

    task automatic test_slow0();
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 16'sd10;
        mem[1] = 16'sd20;
        run_playback("slow0", 2, 1, 2);
    endtask

    task automatic test_slow1();
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 16'sd400;
        mem[1] = -16'sd400;
        mem[2] = 16'sd1000;
        run_playback("slow1", 3, 3, 3);
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'($urandom);
        run_playback("slow1_f1", 3, 0, 5);
    endtask

    task automatic test_random();
        int mode, spd, stop;
        for (int r = 0; r < 6; r++) begin
            mode = $urandom_range(0, 3);
            spd  = $urandom_range(0, 7);
            stop = $urandom_range(1, 8);
            for (int i = 0; i < 64; i++) mem[i] = DATA_W'($urandom);
            run_playback("random", mode, spd, stop);
        end
    endtask

    task automatic test_pause();
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'(1000 + 3 * i);
        set_mode(0, 0);
        i_stop_addr = ADDR_W'(20);
        start_play();
        repeat (5) begin
            tick(1);
            tail(1);
        end
        n_cmp++;
        if (o_sram_addr !== ADDR_W'(5)) begin
            n_bad++;
            $display("FAIL pause_pre addr got %0d want 5", o_sram_addr);
        end
        i_pause = 1'b1;
        @(negedge i_clk);
        i_pause = 1'b0;
        n_cmp++;
        if (o_state !== 2'd2 || o_dac_data !== '0) begin
            n_bad++;
            $display("FAIL pause_enter state/data got %0d/%0d want 2/0", o_state, o_dac_data);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_cmp++;
            if (o_state !== 2'd2 || o_sram_addr !== ADDR_W'(5) || o_dac_data !== '0) begin
                n_bad++;
                $display("FAIL pause_hold[%0d] state/addr/data got %0d/%0d/%0d want 2/5/0",
                         i, o_state, o_sram_addr, o_dac_data);
            end
            tail(1);
        end
        start_play();
        n_cmp++;
        if (o_state !== 2'd1 || o_dac_data !== '0) begin
            n_bad++;
            $display("FAIL resume state/data got %0d/%0d want 1/0", o_state, o_dac_data);
        end
        tick(1);
        n_cmp++;
        if (o_dac_data !== mem[5]) begin
            n_bad++;
            $display("FAIL resume_sample got %0d want %0d", o_dac_data, mem[5]);
        end
        tail(1);
        i_pause = 1'b1;
        @(negedge i_clk);
        i_pause = 1'b0;
        i_stop  = 1'b1;
        @(negedge i_clk);
        i_stop  = 1'b0;
        n_cmp++;
        if (o_state !== 2'd0 || o_sram_addr !== '0) begin
            n_bad++;
            $display("FAIL pause_stop state/addr got %0d/%0d want 0/0", o_state, o_sram_addr);
        end
    endtask

    task automatic test_reset_mid_divide();
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'($urandom) | 16'sh0100;
        set_mode(3, 3);
        i_stop_addr = ADDR_W'(10);
        start_play();
        repeat (5) begin
            tick(LAT_INT);
            tail(LAT_INT);
        end
        tick(5);
        i_stop  = 1'b1;
        i_pause = 1'b1;
        #1 i_rst = 1'b1;
        #1;
        n_cmp++;
        if (o_state !== 2'd0 || o_sram_addr !== '0 || o_dac_data !== '0) begin
            n_bad++;
            $display("FAIL async_reset state/addr/data got %0d/%0d/%0d want 0/0/0",
                     o_state, o_sram_addr, o_dac_data);
        end
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_stop  = 1'b0;
        i_pause = 1'b0;
        i_daclrck = 1'b0;
        repeat (30) @(negedge i_clk);
        n_cmp++;
        if (o_state !== 2'd0 || o_dac_data !== '0) begin
            n_bad++;
            $display("FAIL post_reset state/data got %0d/%0d want 0/0", o_state, o_dac_data);
        end
        set_mode(0, 0);
    endtask

    task automatic test_stop_wins();
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'(50 + i);
        set_mode(0, 0);
        i_stop_addr = ADDR_W'(20);
        start_play();
        repeat (2) begin
            tick(1);
            tail(1);
        end
        i_stop  = 1'b1;
        i_pause = 1'b1;
        @(negedge i_clk);
        i_stop  = 1'b0;
        i_pause = 1'b0;
        n_cmp++;
        if (o_state !== 2'd0 || o_sram_addr !== '0 || o_dac_data !== '0) begin
            n_bad++;
            $display("FAIL stop_over_pause state/addr/data got %0d/%0d/%0d want 0/0/0",
                     o_state, o_sram_addr, o_dac_data);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_fast();
        test_slow0();
        test_slow1();
        test_pause();
        test_reset_mid_divide();
        test_stop_wins();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
